feedforward_section: RTL and testbench

- Numerator (zeros) half of the direct-form IIR filter: x[n] -> sum b_k * x[n-k], k = 0..TAPS-1.
- Sits upstream of the recursive all-pole feedback section and drives its input sample stream.
- Owns its own sample delay line and a programmable coefficient bank.
- Uses one shared signed multiplier that is time-multiplexed over the taps, under a small FSM with valid/ready handshakes on both sides.

---
 rtl/feedforward_section_if.sv | 25 ++
 rtl/feedforward_section.sv | 134 +++++++++++++
 tb/tb_feedforward_section.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/feedforward_section_if.sv
// Sample/result handshake, coefficient write port and status for the feedforward section.
interface feedforward_section_if #(
  parameter int unsigned W = 32
);
  logic signed [W-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                coef_we;
  logic [2:0]          coef_addr;
  logic signed [W-1:0] coef_data;
  logic                busy;

  modport master (
    output in_data, in_valid, out_ready, coef_we, coef_addr, coef_data,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready, coef_we, coef_addr, coef_data,
    output in_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/feedforward_section.sv
// Numerator half of a direct-form IIR filter: y[n] = sat((sum b_k*x[n-k]) >>> FRAC),
// computed with one multiplier time-shared over the taps.
module feedforward_section #(
  parameter int unsigned W    = 32,
  parameter int unsigned TAPS = 5,
  parameter int unsigned FRAC = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  feedforward_section_if.slave bus
);
  localparam int unsigned PROD_W = 2 * W;
  localparam int unsigned ACC_W  = 2 * W + 3;
  localparam int unsigned CNT_W  = $clog2(TAPS);

  localparam logic signed [W-1:0]     COEF_ONE = W'(1) << FRAC;
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic signed [W-1:0]      r_x    [TAPS];
  logic signed [W-1:0]      r_coef [TAPS];
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [W-1:0]      r_out_data;
  logic                     r_out_valid;
  logic                     r_in_ready;
  logic                     r_busy;

  logic                     w_last;
  logic signed [W-1:0]      w_coef_sel;
  logic signed [W-1:0]      w_x_sel;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [W-1:0]      w_sat;

  assign w_last = (r_cnt == CNT_W'(TAPS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)  w_state_next = S_MAC;
      S_MAC:   if (w_last)        w_state_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
      default:                    w_state_next = S_IDLE;
    endcase
  end

  // Tap select feeding the shared multiplier
  always_comb begin
    w_coef_sel = '0;
    w_x_sel    = '0;
    for (int k = 0; k < int'(TAPS); k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_coef_sel = r_coef[k];
        w_x_sel    = r_x[k];
      end
    end
  end

  assign w_prod     = PROD_W'(w_coef_sel) * PROD_W'(w_x_sel);
  assign w_acc_next = r_acc + ACC_W'(w_prod);
  assign w_shift    = w_acc_next >>> FRAC;

  always_comb begin
    w_sat = W'(w_shift);
    if (w_shift > SAT_MAX)      w_sat = W'(SAT_MAX);
    else if (w_shift < SAT_MIN) w_sat = W'(SAT_MIN);
  end

  // Datapath, coefficient bank and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(TAPS); k++) begin
        r_x[k]    <= '0;
        r_coef[k] <= '0;
      end
      r_coef[0]   <= COEF_ONE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_next == S_IDLE);
      r_busy      <= (w_state_next != S_IDLE);
      r_out_valid <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          // Addresses at or above TAPS match no register and are dropped
          if (bus.coef_we) begin
            for (int k = 0; k < int'(TAPS); k++) begin
              if (bus.coef_addr == 3'(k)) r_coef[k] <= bus.coef_data;
            end
          end
          if (bus.in_valid) begin
            r_x[0] <= bus.in_data;
            for (int k = 1; k < int'(TAPS); k++) r_x[k] <= r_x[k-1];
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_out_data <= w_sat;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_feedforward_section.sv
// Directed bench for feedforward_section: pass-through, impulse, FIR, saturation,
// backpressure with dropped coefficient write, and reset mid-computation.
module tb_feedforward_section;
  localparam int unsigned W    = 32;
  localparam int unsigned TAPS = 5;
  localparam int unsigned FRAC = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  feedforward_section_if #(.W(W)) ifc ();

  feedforward_section #(.W(W), .TAPS(TAPS), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_coef(input logic [2:0] a, input logic [31:0] d);
    ifc.coef_we   = 1'b1;
    ifc.coef_addr = a;
    ifc.coef_data = d;
    @(negedge clk);
    ifc.coef_we   = 1'b0;
  endtask

  task automatic set_all(input logic [31:0] d);
    for (int k = 0; k < int'(TAPS); k++) write_coef(3'(k), d);
  endtask

  // Sends one sample with out_ready high; checks latency, in_ready window and result.
  task automatic send_sample(input string tag, input logic [31:0] x, input logic [31:0] exp);
    int n;
    int low;
    bit seen;
    check({tag, "_ready_before"}, 32'(ifc.in_ready), 32'd1);
    ifc.in_valid = 1'b1;
    ifc.in_data  = x;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    n = 1; low = 0; seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (!ifc.in_ready) low++;
      if (ifc.out_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check({tag, "_valid_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(TAPS + 1));
    check({tag, "_data"}, ifc.out_data, exp);
    @(negedge clk);
    if (!ifc.in_ready) low++;
    check({tag, "_valid_drop"}, 32'(ifc.out_valid), 32'd0);
    check({tag, "_ready_low_cycles"}, 32'(low), 32'd6);
  endtask

  initial begin
    int  vcount;
    bit  seen;
    ifc.in_data   = '0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    ifc.coef_we   = 1'b0;
    ifc.coef_addr = '0;
    ifc.coef_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_out_data",  ifc.out_data,       32'd0);
    check("rst_in_ready",  32'(ifc.in_ready),  32'd1);
    check("rst_busy",      32'(ifc.busy),      32'd0);

    // Unity pass-through with reset coefficients
    send_sample("t1_100",  32'd100,        32'd100);
    send_sample("t1_m7",   32'hFFFF_FFF9,  32'hFFFF_FFF9);
    send_sample("t1_max",  32'd32767,      32'd32767);

    // All taps 1.0: impulse spreads over five outputs then leaves
    do_reset();
    set_all(32'd16384);
    send_sample("t2_imp", 32'd1000, 32'd1000);
    for (int i = 0; i < 4; i++) send_sample("t2_tail", 32'd0, 32'd1000);
    send_sample("t2_gone", 32'd0, 32'd0);

    // b0 = 0.5, b1 = -0.5
    write_coef(3'd0, 32'd8192);
    write_coef(3'd1, 32'hFFFF_E000);
    write_coef(3'd2, 32'd0);
    write_coef(3'd3, 32'd0);
    write_coef(3'd4, 32'd0);
    send_sample("t3_a", 32'd4000, 32'd2000);
    send_sample("t3_b", 32'd2000, 32'hFFFF_FC18);
    send_sample("t3_c", 32'd2000, 32'd0);

    // Saturation both ways
    set_all(32'h7FFF_FFFF);
    for (int i = 0; i < 5; i++) send_sample("t4_pos", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    set_all(32'h8000_0000);
    send_sample("t4_neg", 32'h7FFF_FFFF, 32'h8000_0000);

    // Backpressure: result held, coefficient write in DONE dropped
    do_reset();
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 32'd123;
    @(negedge clk);
    ifc.in_valid  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (ifc.out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check("t5_valid_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", 32'(ifc.out_valid), 32'd1);
      check("t5_hold_data",  ifc.out_data,       32'd123);
      check("t5_hold_ready", 32'(ifc.in_ready),  32'd0);
      if (i == 2) begin
        ifc.coef_we   = 1'b1;
        ifc.coef_addr = 3'd0;
        ifc.coef_data = 32'd49152;
      end
      if (i == 3) ifc.coef_we = 1'b0;
      @(negedge clk);
    end
    ifc.out_ready = 1'b1;
    @(negedge clk);
    check("t5_release", 32'(ifc.out_valid), 32'd0);
    send_sample("t5_coef_kept", 32'd10, 32'd10);

    // Reset on the third MAC cycle discards the sample and clears the delay line
    set_all(32'd16384);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 32'd77;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    check("t6_busy_mac", 32'(ifc.busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_ready_after_rst", 32'(ifc.in_ready), 32'd1);
    check("t6_busy_after_rst",  32'(ifc.busy),     32'd0);
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (ifc.out_valid) vcount++;
      @(negedge clk);
    end
    check("t6_no_valid", 32'(vcount), 32'd0);
    send_sample("t6_imp50", 32'd50, 32'd50);
    set_all(32'd16384);
    send_sample("t6_line_clear", 32'd0, 32'd50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
